// File: rtl/seq_detect_param.sv
// Parametrised Mealy sequence detector with KMP mismatch recovery, overlap mode and saturating
// match counter. Define SEQ_DET_REGOUT_EN to register `out` (one-cycle pulse after the match).
module seq_detect_param #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in,
    input  logic                     overlap,
    input  logic                     clr,
    output logic                     out,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [$clog2(PAT_W)-1:0] state
);
    localparam int unsigned SW = $clog2(PAT_W);
    typedef logic [SW-1:0] k_t;

    // Bit i of the pattern in arrival order (i = 0 is the first bit expected).
    function automatic logic pbit(input int i);
        return PATTERN[PAT_W-1-i];
    endfunction

    // Failure-transition table indexed by {k, b}: longest pattern prefix that is a suffix of
    // (prefix of length k followed by b), capped at PAT_W-1.
    function automatic logic [2*PAT_W*SW-1:0] build_next();
        logic [2*PAT_W*SW-1:0] tbl;
        tbl = '0;
        for (int k = 0; k < PAT_W; k++) begin
            for (int b = 0; b < 2; b++) begin
                int best;
                best = 0;
                for (int l = 1; l < PAT_W; l++) begin
                    if (l <= k + 1) begin
                        logic ok;
                        ok = 1'b1;
                        for (int i = 0; i < l; i++) begin
                            int   j;
                            logic sb;
                            j  = k + 1 - l + i;
                            sb = (j < k) ? pbit(j) : b[0];
                            if (sb != pbit(i)) ok = 1'b0;
                        end
                        if (ok) best = l;
                    end
                end
                tbl[(2*k+b)*SW +: SW] = best[SW-1:0];
            end
        end
        return tbl;
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic int build_border();
        int best;
        best = 0;
        for (int l = 1; l < PAT_W; l++) begin
            logic ok;
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                if (pbit(i) != pbit(PAT_W - l + i)) ok = 1'b0;
            end
            if (ok) best = l;
        end
        return best;
    endfunction

    localparam logic [2*PAT_W*SW-1:0] NEXT_TBL = build_next();
    localparam int                    BORDER_I = build_border();
    localparam k_t                    K_BORDER = k_t'(BORDER_I);
    localparam k_t                    K_LAST   = k_t'(PAT_W - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = '1;

    k_t               k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q   <= '0;
            cnt_q <= '0;
        end else begin
            k_q   <= k_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        hit   = in_valid & ~clr & (k_q == K_LAST) & (in == PATTERN[0]);
        k_d   = k_q;
        cnt_d = cnt_q;
        if (clr) begin
            k_d   = '0;
            cnt_d = '0;
        end else if (hit) begin
            k_d = overlap ? K_BORDER : '0;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else if (in_valid) begin
            k_d = NEXT_TBL[int'({k_q, in}) * SW +: SW];
        end
    end

`ifdef SEQ_DET_REGOUT_EN
    logic out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_q <= 1'b0;
        else       out_q <= hit;
    end

    always_comb begin
        out = out_q;
    end
`else
    always_comb begin
        out = hit & ~reset;
    end
`endif

    assign state     = k_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: three instances (1010, 1101, 1010 with 2-bit counter)
// share stimulus; a history-based reference model pushes expectations checked at each negedge.
module tb_seq_detect_param;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_bit;
    logic       overlap;
    logic       clr;
    logic       out_a, out_b, out_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic [1:0] st_a, st_b, st_c;

    seq_detect_param u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_bit), .overlap(overlap),
        .clr(clr), .out(out_a), .match_cnt(cnt_a), .state(st_a)
    );

    seq_detect_param #(.PATTERN(4'b1101)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_bit), .overlap(overlap),
        .clr(clr), .out(out_b), .match_cnt(cnt_b), .state(st_b)
    );

    seq_detect_param #(.CNT_W(2)) u_dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_bit), .overlap(overlap),
        .clr(clr), .out(out_c), .match_cnt(cnt_c), .state(st_c)
    );

    typedef struct {
        logic [2:0] out;
        int         st  [3];
        int         cnt [3];
    } exp_t;

    localparam logic [3:0] PATS [3] = '{4'b1010, 4'b1101, 4'b1010};
    localparam int         CMAX [3] = '{255, 255, 3};

    exp_t        sb_q [$];
    exp_t        mon_e;
    logic [31:0] hist     [3];
    int          hlen     [3];
    int          mcnt     [3];
    logic        prev_hit [3];
    int          n_checks = 0;
    int          n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            hist[d]     = '0;
            hlen[d]     = 0;
            mcnt[d]     = 0;
            prev_hit[d] = 1'b0;
        end
    endtask

    // Longest pattern prefix (<= 3) that ends the history accepted since the last restart.
    function automatic int model_k(input int d);
        logic [3:0] p;
        p = PATS[d];
        for (int l = 3; l >= 1; l--) begin
            if (l <= hlen[d]) begin
                logic ok;
                ok = 1'b1;
                for (int i = 0; i < l; i++) begin
                    if (hist[d][l-1-i] != p[3-i]) ok = 1'b0;
                end
                if (ok) return l;
            end
        end
        return 0;
    endfunction

    task automatic drive(input logic v, input logic b, input logic ov, input logic c);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        in_bit   = b;
        overlap  = ov;
        clr      = c;
        for (int d = 0; d < 3; d++) begin
            logic [31:0] nh;
            logic        h;
            nh       = {hist[d][30:0], b};
            h        = v & ~c & (hlen[d] >= 3) & (nh[3:0] == PATS[d]);
            e.st[d]  = model_k(d);
            e.cnt[d] = mcnt[d];
`ifdef SEQ_DET_REGOUT_EN
            e.out[d]    = prev_hit[d];
            prev_hit[d] = h;
`else
            e.out[d] = h;
`endif
            if (c) begin
                hlen[d] = 0;
                mcnt[d] = 0;
            end else if (v) begin
                hist[d] = nh;
                if (hlen[d] < 32) hlen[d]++;
                if (h) begin
                    if (mcnt[d] < CMAX[d]) mcnt[d]++;
                    if (!ov) hlen[d] = 0;
                end
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic drive_word(input logic [3:0] w, input logic ov);
        logic [3:0] wv;
        wv = w;
        for (int i = 3; i >= 0; i--) drive(1'b1, wv[i], ov, 1'b0);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("out_a", int'(out_a), int'(mon_e.out[0]));
            check("out_b", int'(out_b), int'(mon_e.out[1]));
            check("out_c", int'(out_c), int'(mon_e.out[2]));
            check("state_a", int'(st_a), mon_e.st[0]);
            check("state_b", int'(st_b), mon_e.st[1]);
            check("state_c", int'(st_c), mon_e.st[2]);
            check("cnt_a", int'(cnt_a), mon_e.cnt[0]);
            check("cnt_b", int'(cnt_b), mon_e.cnt[1]);
            check("cnt_c", int'(cnt_c), mon_e.cnt[2]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b0;
        overlap  = 1'b1;
        clr      = 1'b0;
        #3;
        check("rst_out_a", int'(out_a), 0);
        check("rst_state_a", int'(st_a), 0);
        check("rst_cnt_a", int'(cnt_a), 0);
        check("rst_cnt_c", int'(cnt_c), 0);
        #7;
        reset = 1'b0;

        // Basic overlapping match.
        drive_word(4'b1010, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // 101010 overlapping, then non-overlapping.
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive_word(4'b1010, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive_word(4'b1010, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Valid-gapped stream with junk on invalid cycles.
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i % 2 == 0), 1'b1, 1'b0);
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        // 11101 exercises the 1101 failure transitions.
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive_word(4'b1110, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Counter saturation, then clr on a matching edge.
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) drive_word(4'b1010, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-pattern.
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_bit   = 1'b0;
        #1;
`ifdef SEQ_DET_REGOUT_EN
        check("pre_rst_out_a", int'(out_a), 0);
`else
        check("pre_rst_out_a", int'(out_a), 1);
`endif
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_out_a", int'(out_a), 0);
        check("async_rst_state_a", int'(st_a), 0);
        check("async_rst_state_b", int'(st_b), 0);
        check("async_rst_cnt_a", int'(cnt_a), 0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive_word(4'b1010, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Random traffic with occasional clr and mode changes.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        check("sb_drain", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
